// File: rtl/matrix_mult_core_p.sv
// Parametrised matrix multiplier: loads A and B into local storage, computes C = A x B
// with one multiply-accumulate per cycle and streams C out row-major with backpressure.
module matrix_mult_core_p #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 4,
  parameter int OUT_W   = 20,
  localparam int DIM_W  = $clog2(MAX_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  a_rows_m1,
  input  logic [DIM_W-1:0]  a_cols_m1,
  input  logic [DIM_W-1:0]  b_rows_m1,
  input  logic [DIM_W-1:0]  b_cols_m1,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DIM_W-1:0]  in_row,
  input  logic [DIM_W-1:0]  in_col,
  input  logic [DATA_W-1:0] in_data,
  input  logic              go,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_last,
  output logic              out_sat,
  output logic              err_dim,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam int ACC_W  = 2 * DATA_W + DIM_W;
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam int WIDE_W = (OUT_W > ACC_W) ? OUT_W : ACC_W;

  localparam logic signed [WIDE_W:0] SMAX = {{(WIDE_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [WIDE_W:0] SMIN = {{(WIDE_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [WIDE_W:0] UMAX = {{(WIDE_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [OUT_W-1:0] SMAX_OUT = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN_OUT = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX_OUT = {OUT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  assign state_dbg = state;

  logic [DATA_W-1:0] a_mem [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] b_mem [MAX_DIM][MAX_DIM];

  logic [DIM_W-1:0] a_rows_q, a_cols_q, b_rows_q, b_cols_q;
  logic             sgn_q;
  logic [DIM_W-1:0] r_idx, c_idx, k_idx;
  logic signed [ACC_W-1:0] acc;

  logic [DATA_W-1:0]        a_raw, b_raw;
  logic signed [DATA_W:0]   a_op, b_op;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [WIDE_W:0]   acc_ext;
  logic [OUT_W-1:0]         sat_data;
  logic                     sat_flag;
  logic                     wr_ok;

  // Operands get one extra bit so a single signed multiplier serves both modes.
  always_comb begin
    a_raw    = a_mem[r_idx][k_idx];
    b_raw    = b_mem[k_idx][c_idx];
    a_op     = {sgn_q & a_raw[DATA_W-1], a_raw};
    b_op     = {sgn_q & b_raw[DATA_W-1], b_raw};
    prod     = a_op * b_op;
    acc_next = acc + ACC_W'(prod);
  end

  always_comb begin
    if (sgn_q) acc_ext = {{(WIDE_W + 1 - ACC_W){acc_next[ACC_W-1]}}, acc_next};
    else       acc_ext = {{(WIDE_W + 1 - ACC_W){1'b0}}, acc_next};
    sat_data = acc_ext[OUT_W-1:0];
    sat_flag = 1'b0;
    if (sgn_q) begin
      if (acc_ext > SMAX) begin
        sat_data = SMAX_OUT;
        sat_flag = 1'b1;
      end else if (acc_ext < SMIN) begin
        sat_data = SMIN_OUT;
        sat_flag = 1'b1;
      end
    end else if (acc_ext > UMAX) begin
      sat_data = UMAX_OUT;
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    if (in_sel) wr_ok = (in_row <= b_rows_q) && (in_col <= b_cols_q);
    else        wr_ok = (in_row <= a_rows_q) && (in_col <= a_cols_q);
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high for the whole LOAD state; out_valid rises in EMIT and the out_*
  // fields stay frozen until the edge where out_ready is seen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      end
      a_rows_q  <= '0;
      a_cols_q  <= '0;
      b_rows_q  <= '0;
      b_cols_q  <= '0;
      sgn_q     <= 1'b0;
      r_idx     <= '0;
      c_idx     <= '0;
      k_idx     <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      err_dim   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_rows_q <= a_rows_m1;
            a_cols_q <= a_cols_m1;
            b_rows_q <= b_rows_m1;
            b_cols_q <= b_cols_m1;
            sgn_q    <= signed_mode;
            err_dim  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && wr_ok) begin
            if (in_sel) b_mem[in_row][in_col] <= in_data;
            else        a_mem[in_row][in_col] <= in_data;
          end
          if (go) begin
            in_ready <= 1'b0;
            if (a_cols_q != b_rows_q) begin
              err_dim <= 1'b1;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              r_idx <= '0;
              c_idx <= '0;
              k_idx <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (k_idx == a_cols_q) begin
            out_data  <= sat_data;
            out_sat   <= sat_flag;
            out_row   <= r_idx;
            out_col   <= c_idx;
            out_last  <= (r_idx == a_rows_q) && (c_idx == b_cols_q);
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              if (c_idx == b_cols_q) begin
                c_idx <= '0;
                r_idx <= r_idx + 1'b1;
              end else begin
                c_idx <= c_idx + 1'b1;
              end
              k_idx <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
